// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard receiver
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

    // keyboardData bit positions
    localparam int KBD_VALID_BIT = 15;
    localparam int KBD_OVF_BIT   = 14;
    localparam int KBD_BREAK_BIT = 8;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// rtl/ps2_fifo.sv - small synchronous FIFO holding received scan-code entries
//
// Ports: clk_i, rst_ni (async active-low), push_i/wdata_i write side,
// pop_i read side, full_o/empty_o status, head_o = oldest entry.
// A pop on an empty FIFO is ignored; a push on a full FIFO lands only if
// a pop happens in the same cycle.
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard receiver with scan-code FIFO and interrupt request
//
// Ports: clk, rst (async active-low), ps2Clk/ps2Data raw PS/2 lines,
// dataAck pop strobe, keyboardData {valid, overflow, 5'b0, break, code},
// hardwareInterruptSignal/hardwareInterruptIndex interrupt request.
// Optional macro PS2_BREAK_FILTER_EN: fold the 0xF0 prefix into bit 8 of
// the following byte instead of queueing it.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 8,
    parameter int         FILTER_LEN     = 4,
    parameter int         TIMEOUT_CYCLES = 25000,
    parameter logic [3:0] IRQ_INDEX      = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2Clk,
    input  logic        ps2Data,
    input  logic        dataAck,
    output logic [15:0] keyboardData,
    output logic        hardwareInterruptSignal,
    output logic [3:0]  hardwareInterruptIndex
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          filt_fall, rx_bit;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          ovf_q, ovf_d;

    logic          push;
    logic [8:0]    push_data;
    logic          fifo_full, fifo_empty;
    logic [8:0]    fifo_head;

`ifdef PS2_BREAK_FILTER_EN
    logic brk_q, brk_d;
`endif

    // Filtered clock follows the synchronised clock only after FILTER_LEN
    // consecutive disagreeing samples; any agreeing sample restarts the run.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
            else                                   filt_cnt_d = filt_cnt_q + FW'(1);
        end
    end

    assign filt_fall = filt_q & ~filt_d;
    assign rx_bit    = data_sync_q[1];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        to_cnt_d  = to_cnt_q;
        push      = 1'b0;
        push_data = 9'd0;
`ifdef PS2_BREAK_FILTER_EN
        brk_d     = brk_q;
`endif

        // Mid-frame watchdog: restarted by every edge, aborts a stalled frame.
        if (state_q == ST_IDLE || filt_fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_d = '0;
            state_d  = ST_IDLE;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        if (filt_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {rx_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_ok_d = odd_parity_ok(shift_q, rx_bit);
                    state_d  = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (rx_bit && par_ok_q) begin
`ifdef PS2_BREAK_FILTER_EN
                        if (shift_q == PS2_BREAK_CODE) begin
                            brk_d = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_data = {brk_q, shift_q};
                            brk_d     = 1'b0;
                        end
`else
                        push      = 1'b1;
                        push_data = {1'b0, shift_q};
`endif
                    end
                end
            endcase
        end

        // Any ack clears overflow; a push onto a full FIFO with no ack sets it.
        if (dataAck)                ovf_d = 1'b0;
        else if (push && fifo_full) ovf_d = 1'b1;
        else                        ovf_d = ovf_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            par_ok_q    <= 1'b0;
            to_cnt_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2Clk};
            data_sync_q <= {data_sync_q[0], ps2Data};
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            to_cnt_q    <= to_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) brk_q <= 1'b0;
        else      brk_q <= brk_d;
    end
`endif

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push),
        .pop_i   (dataAck),
        .wdata_i (push_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_comb begin
        keyboardData                = 16'd0;
        keyboardData[KBD_VALID_BIT] = ~fifo_empty;
        keyboardData[KBD_OVF_BIT]   = ovf_q;
        keyboardData[KBD_BREAK_BIT:0] = fifo_empty ? 9'd0 : fifo_head;
    end

    assign hardwareInterruptSignal = ~fifo_empty;
    assign hardwareInterruptIndex  = fifo_empty ? 4'd0 : IRQ_INDEX;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - self-checking bench for ps2_keyboard
module tb_ps2_keyboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2Clk;
    logic        ps2Data;
    logic        dataAck;
    logic [15:0] keyboardData;
    logic        hardwareInterruptSignal;
    logic [3:0]  hardwareInterruptIndex;

    int tests = 0;
    int fails = 0;

    ps2_keyboard dut (
        .clk                     (clk),
        .rst                     (rst),
        .ps2Clk                  (ps2Clk),
        .ps2Data                 (ps2Data),
        .dataAck                 (dataAck),
        .keyboardData            (keyboardData),
        .hardwareInterruptSignal (hardwareInterruptSignal),
        .hardwareInterruptIndex  (hardwareInterruptIndex)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        bad_par;
        logic        bad_stop;
        logic [15:0] exp_kd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_irq(input string name, input logic exp_irq);
        check(name, {11'd0, hardwareInterruptSignal, hardwareInterruptIndex},
              {11'd0, exp_irq, exp_irq ? 4'd1 : 4'd0});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2Data = b;
        cyc(4);
        ps2Clk = 1'b0;
        cyc(8);
        ps2Clk = 1'b1;
        cyc(4);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_par);
        send_bit(~bad_stop);
        ps2Data = 1'b1;
        cyc(4);
    endtask

    task automatic ack();
        dataAck = 1'b1;
        cyc(1);
        dataAck = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b0, 16'h801C, 1'b1};
        vecs[1] = '{8'h1C, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{8'h1C, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 16'h8000, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 16'h80FF, 1'b1};
        vecs[5] = '{8'h80, 1'b0, 1'b0, 16'h8080, 1'b1};

        rst     = 1'b0;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        dataAck = 1'b0;
        cyc(3);
        check("reset_kd", keyboardData, 16'h0000);
        check_irq("reset_irq", 1'b0);
        rst = 1'b1;
        cyc(2);
        check("post_reset_kd", keyboardData, 16'h0000);
        ack();
        check("ack_empty_kd", keyboardData, 16'h0000);

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop);
            check($sformatf("vec%0d_kd", v), keyboardData, vecs[v].exp_kd);
            check_irq($sformatf("vec%0d_irq", v), vecs[v].exp_irq);
            if (vecs[v].exp_irq) begin
                ack();
                check($sformatf("vec%0d_ack_kd", v), keyboardData, 16'h0000);
                check_irq($sformatf("vec%0d_ack_irq", v), 1'b0);
            end
        end

        // Overflow: nine frames into an eight-entry FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        check("ovf_kd", keyboardData, 16'hC001);
        check_irq("ovf_irq", 1'b1);
        for (int i = 2; i <= 8; i++) begin
            ack();
            check($sformatf("drain_%0d", i), keyboardData, 16'h8000 | 16'(i));
        end
        ack();
        check("drain_empty", keyboardData, 16'h0000);
        check_irq("drain_irq", 1'b0);

        // Timeout: partial frame abandoned, next frame must still decode.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2Data = 1'b1;
        cyc(25100);
        check("timeout_kd", keyboardData, 16'h0000);
        send_frame(8'h2A, 1'b0, 1'b0);
        check("after_timeout_kd", keyboardData, 16'h802A);
        ack();

        // Glitch shorter than the filter must not start a frame.
        ps2Data = 1'b0;
        ps2Clk  = 1'b0;
        cyc(2);
        ps2Clk  = 1'b1;
        cyc(10);
        ps2Data = 1'b1;
        cyc(4);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("glitch_kd", keyboardData, 16'h801C);
        ack();

        // Break prefix handling.
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
        check("break_kd", keyboardData, 16'h811C);
        ack();
        check("break_empty", keyboardData, 16'h0000);
`else
        check("raw_f0_kd", keyboardData, 16'h80F0);
        ack();
        check("raw_1c_kd", keyboardData, 16'h801C);
        ack();
        check("raw_empty", keyboardData, 16'h0000);
`endif

        // Reset mid-frame with a non-empty FIFO.
        send_frame(8'h33, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b0;
        cyc(2);
        check("midreset_kd", keyboardData, 16'h0000);
        check_irq("midreset_irq", 1'b0);
        rst     = 1'b1;
        ps2Data = 1'b1;
        cyc(4);
        send_frame(8'h44, 1'b0, 1'b0);
        check("after_reset_kd", keyboardData, 16'h8044);
        ack();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
